// File: rtl/frame_spot_tracker_pkg.sv
// frame_spot_tracker_pkg
//   Shared definitions for the frame spot tracker: the FSM state encoding and
//   the RGB333 field positions (the camera packing logic uses the same layout),
//   plus the brightness helper built on those positions.
package frame_spot_tracker_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Pixel layout {R[2:0], G[2:0], B[2:0]}
   localparam int unsigned PIX_R_MSB = 8;
   localparam int unsigned PIX_R_LSB = 6;
   localparam int unsigned PIX_G_MSB = 5;
   localparam int unsigned PIX_G_LSB = 3;
   localparam int unsigned PIX_B_MSB = 2;
   localparam int unsigned PIX_B_LSB = 0;

   // R+G+B, range 0..21
   function automatic logic [4:0] pixel_brightness(input logic [8:0] pix);
      return 5'(pix[PIX_R_MSB:PIX_R_LSB])
           + 5'(pix[PIX_G_MSB:PIX_G_LSB])
           + 5'(pix[PIX_B_MSB:PIX_B_LSB]);
   endfunction

endpackage

// File: rtl/frame_spot_tracker_if.sv
// frame_spot_tracker_if
//   Framebuffer read port.
//   read_addr   16  read address {y, x}
//   dout_pixel   9  RGB333 data, valid READ_LATENCY cycles after read_addr
//   master: the reader (tracker); slave: the framebuffer.
interface frame_spot_tracker_if;
   logic [15:0] read_addr;
   logic [8:0]  dout_pixel;

   modport master (output read_addr, input  dout_pixel);
   modport slave  (input  read_addr, output dout_pixel);
endinterface

// File: rtl/frame_spot_tracker_coord_delay.sv
// coord_delay_line
//   DEPTH-stage register pipe carrying {valid, y, x} alongside the framebuffer
//   read latency so coordinates line up with the returned pixel.
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset, clears every stage
//   in_data   in   W  value entering the pipe
//   out_data  out  W  value from DEPTH cycles earlier
module coord_delay_line #(
   parameter int unsigned DEPTH = 1,
   parameter int unsigned W     = 17
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] in_data,
   output logic [W-1:0] out_data
);

   logic [W-1:0] stage_q [DEPTH];
   logic [W-1:0] stage_d [DEPTH];

   always_comb begin
      stage_d[0] = in_data;
      for (int unsigned i = 1; i < DEPTH; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   assign out_data = stage_q[DEPTH-1];

endmodule

// File: rtl/frame_spot_tracker.sv
// frame_spot_tracker
//   Raster-scans one stored frame on start, thresholds each RGB333 pixel on
//   R+G+B and reports the count and bounding box of bright pixels.
//   clk_read      in   clock (framebuffer read clock)
//   rst_n         in   asynchronous active-low reset
//   start         in   1-cycle scan request, ignored unless idle
//   threshold     in   5  brightness threshold, sampled with start
//   fb            master framebuffer read port (read_addr / dout_pixel)
//   busy          out  scan in progress
//   done          out  1-cycle pulse, results updated in the same cycle
//   found         out  last scan had at least one bright pixel
//   count         out  17 bright pixel count of last scan
//   x_min..y_max  out  8  bounding box of last scan, 0 when nothing found
module frame_spot_tracker
   import frame_spot_tracker_pkg::*;
#(
   parameter int unsigned IMG_W_LOG2   = 8,
   parameter int unsigned IMG_H        = 240,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic                 clk_read,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [4:0]           threshold,
   frame_spot_tracker_if.master fb,
   output logic                 busy,
   output logic                 done,
   output logic                 found,
   output logic [16:0]          count,
   output logic [7:0]           x_min,
   output logic [7:0]           x_max,
   output logic [7:0]           y_min,
   output logic [7:0]           y_max
);

   localparam int unsigned XW         = IMG_W_LOG2;
   localparam logic [15:0] LAST_ADDR  = 16'((IMG_H << IMG_W_LOG2) - 1);
   localparam logic [1:0]  DRAIN_LAST = 2'(READ_LATENCY - 1);

   state_e      state_q, state_d;
   logic [4:0]  thr_q, thr_d;
   logic [15:0] addr_q, addr_d;
   logic [1:0]  drain_q, drain_d;
   logic [16:0] acc_cnt_q, acc_cnt_d;
   logic [7:0]  acc_xmin_q, acc_xmin_d, acc_xmax_q, acc_xmax_d;
   logic [7:0]  acc_ymin_q, acc_ymin_d, acc_ymax_q, acc_ymax_d;
   logic        busy_q, busy_d, done_q, done_d, found_q, found_d;
   logic [16:0] count_q, count_d;
   logic [7:0]  x_min_q, x_min_d, x_max_q, x_max_d;
   logic [7:0]  y_min_q, y_min_d, y_max_q, y_max_d;

   logic [16:0] dly;
   logic        dly_valid, hit;
   logic [7:0]  dly_x, dly_y;

   coord_delay_line #(
      .DEPTH (READ_LATENCY),
      .W     (17)
   ) u_coord_dly (
      .clk      (clk_read),
      .rst_n    (rst_n),
      .in_data  ({state_q == ST_SCAN, addr_q}),
      .out_data (dly)
   );

   assign dly_valid = dly[16];
   assign dly_x     = 8'(dly[XW-1:0]);
   assign dly_y     = 8'(dly[15:XW]);
   assign hit       = dly_valid && (pixel_brightness(fb.dout_pixel) >= thr_q);

   always_comb begin
      state_d    = state_q;
      thr_d      = thr_q;
      addr_d     = addr_q;
      drain_d    = drain_q;
      acc_cnt_d  = acc_cnt_q;
      acc_xmin_d = acc_xmin_q;
      acc_xmax_d = acc_xmax_q;
      acc_ymin_d = acc_ymin_q;
      acc_ymax_d = acc_ymax_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      found_d    = found_q;
      count_d    = count_q;
      x_min_d    = x_min_q;
      x_max_d    = x_max_q;
      y_min_d    = y_min_q;
      y_max_d    = y_max_q;

      if (hit) begin
         acc_cnt_d = acc_cnt_q + 17'd1;
         if (dly_x < acc_xmin_q) acc_xmin_d = dly_x;
         if (dly_x > acc_xmax_q) acc_xmax_d = dly_x;
         if (dly_y < acc_ymin_q) acc_ymin_d = dly_y;
         if (dly_y > acc_ymax_q) acc_ymax_d = dly_y;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_SCAN;
               thr_d      = threshold;
               addr_d     = '0;
               acc_cnt_d  = '0;
               acc_xmin_d = '1;
               acc_xmax_d = '0;
               acc_ymin_d = '1;
               acc_ymax_d = '0;
               busy_d     = 1'b1;
            end
         end
         ST_SCAN: begin
            // {y, x} + 1 carries x wrap into y
            if (addr_q == LAST_ADDR) begin
               state_d = ST_DRAIN;
               drain_d = '0;
            end else begin
               addr_d = addr_q + 16'd1;
            end
         end
         ST_DRAIN: begin
            if (drain_q == DRAIN_LAST) begin
               // Results come from the accumulator next-state so the pixel
               // arriving on this last drain edge is included; done is
               // registered here so it is high during the DONE state.
               state_d = ST_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               count_d = acc_cnt_d;
               found_d = (acc_cnt_d != '0);
               x_min_d = found_d ? acc_xmin_d : '0;
               x_max_d = found_d ? acc_xmax_d : '0;
               y_min_d = found_d ? acc_ymin_d : '0;
               y_max_d = found_d ? acc_ymax_d : '0;
            end else begin
               drain_d = drain_q + 2'd1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_read or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         thr_q      <= '0;
         addr_q     <= '0;
         drain_q    <= '0;
         acc_cnt_q  <= '0;
         acc_xmin_q <= '0;
         acc_xmax_q <= '0;
         acc_ymin_q <= '0;
         acc_ymax_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         found_q    <= 1'b0;
         count_q    <= '0;
         x_min_q    <= '0;
         x_max_q    <= '0;
         y_min_q    <= '0;
         y_max_q    <= '0;
      end else begin
         state_q    <= state_d;
         thr_q      <= thr_d;
         addr_q     <= addr_d;
         drain_q    <= drain_d;
         acc_cnt_q  <= acc_cnt_d;
         acc_xmin_q <= acc_xmin_d;
         acc_xmax_q <= acc_xmax_d;
         acc_ymin_q <= acc_ymin_d;
         acc_ymax_q <= acc_ymax_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         found_q    <= found_d;
         count_q    <= count_d;
         x_min_q    <= x_min_d;
         x_max_q    <= x_max_d;
         y_min_q    <= y_min_d;
         y_max_q    <= y_max_d;
      end
   end

   assign fb.read_addr = addr_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign found        = found_q;
   assign count        = count_q;
   assign x_min        = x_min_q;
   assign x_max        = x_max_q;
   assign y_min        = y_min_q;
   assign y_max        = y_max_q;

endmodule

// File: tb/tb_frame_spot_tracker.sv
// tb_frame_spot_tracker
//   Directed bench. Two trackers share one frame store: dut1 with READ_LATENCY=1
//   and dut3 with READ_LATENCY=3; both must report identical results.
//   The frame is shrunk to 64 x 60 (IMG_W_LOG2=6, IMG_H=60) so each scan is
//   3840 cycles; test coordinates are scaled to fit (far corner is (63,59)).
module tb_frame_spot_tracker;

   localparam int NPIX = 64 * 60;

   logic        clk_read = 1'b0;
   logic        rst_n;
   logic        start;
   logic [4:0]  threshold;

   always #5 clk_read = ~clk_read;

   frame_spot_tracker_if fb1();
   frame_spot_tracker_if fb3();

   logic        busy1, done1, found1, busy3, done3, found3;
   logic [16:0] count1, count3;
   logic [7:0]  xmin1, xmax1, ymin1, ymax1, xmin3, xmax3, ymin3, ymax3;

   frame_spot_tracker #(.IMG_W_LOG2(6), .IMG_H(60), .READ_LATENCY(1)) dut1 (
      .clk_read (clk_read), .rst_n (rst_n), .start (start), .threshold (threshold),
      .fb (fb1), .busy (busy1), .done (done1), .found (found1), .count (count1),
      .x_min (xmin1), .x_max (xmax1), .y_min (ymin1), .y_max (ymax1)
   );

   frame_spot_tracker #(.IMG_W_LOG2(6), .IMG_H(60), .READ_LATENCY(3)) dut3 (
      .clk_read (clk_read), .rst_n (rst_n), .start (start), .threshold (threshold),
      .fb (fb3), .busy (busy3), .done (done3), .found (found3), .count (count3),
      .x_min (xmin3), .x_max (xmax3), .y_min (ymin3), .y_max (ymax3)
   );

   // Frame store with per-port read latency
   logic [8:0] frame [0:65535];
   logic [8:0] rd1 = '0, rd3a = '0, rd3b = '0, rd3c = '0;

   always @(posedge clk_read) begin
      rd1  <= frame[fb1.read_addr];
      rd3a <= frame[fb3.read_addr];
      rd3b <= rd3a;
      rd3c <= rd3b;
   end

   assign fb1.dout_pixel = rd1;
   assign fb3.dout_pixel = rd3c;

   int checks   = 0;
   int failures = 0;
   int ndone1, ndone3, lat1, lat3;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic clear_frame();
      for (int i = 0; i < 65536; i++) frame[i] = '0;
   endtask

   task automatic set_px(input int x, input int y, input logic [8:0] v);
      frame[y * 64 + x] = v;
   endtask

   // Starts a scan and watches both DUTs for up to NPIX+12 cycles (or stop_at).
   // start is re-pulsed in the cycle following watch cycle inj_a / inj_b.
   task automatic run_scan(input string tag, input logic [4:0] thr,
                           input int inj_a, input int inj_b, input int stop_at);
      int last;
      @(negedge clk_read);
      start     = 1'b1;
      threshold = thr;
      @(posedge clk_read);
      #1;
      start     = 1'b0;
      threshold = ~thr;
      ndone1 = 0; ndone3 = 0; lat1 = 0; lat3 = 0;
      last = (stop_at > 0) ? stop_at : NPIX + 12;
      for (int cyc = 1; cyc <= last; cyc++) begin
         @(posedge clk_read);
         #1;
         start = (cyc == inj_a) || (cyc == inj_b);
         if (cyc == 1) begin
            check_val({tag, " busy1 after start"}, 32'(busy1), 1);
            check_val({tag, " busy3 after start"}, 32'(busy3), 1);
         end
         if (done1) begin
            ndone1++;
            if (lat1 == 0) begin
               lat1 = cyc + 1;
               check_val({tag, " busy1 at done"}, 32'(busy1), 0);
            end
         end
         if (done3) begin
            ndone3++;
            if (lat3 == 0) begin
               lat3 = cyc + 1;
               check_val({tag, " busy3 at done"}, 32'(busy3), 0);
            end
         end
      end
      start = 1'b0;
      if (stop_at > 0) begin
         check_val({tag, " no done1 before reset"}, 32'(ndone1), 0);
         check_val({tag, " no done3 before reset"}, 32'(ndone3), 0);
      end else begin
         check_val({tag, " done1 pulses"}, 32'(ndone1), 1);
         check_val({tag, " done3 pulses"}, 32'(ndone3), 1);
         check_val({tag, " done1 latency"}, 32'(lat1), 32'(NPIX + 2));
         check_val({tag, " done3 latency"}, 32'(lat3), 32'(NPIX + 4));
      end
   endtask

   task automatic check_res(input string tag, input int ecnt, input int exmin,
                            input int exmax, input int eymin, input int eymax);
      check_val({tag, " count1"}, 32'(count1), 32'(ecnt));
      check_val({tag, " found1"}, 32'(found1), 32'(ecnt != 0));
      check_val({tag, " x_min1"}, 32'(xmin1), 32'(exmin));
      check_val({tag, " x_max1"}, 32'(xmax1), 32'(exmax));
      check_val({tag, " y_min1"}, 32'(ymin1), 32'(eymin));
      check_val({tag, " y_max1"}, 32'(ymax1), 32'(eymax));
      check_val({tag, " count3"}, 32'(count3), 32'(ecnt));
      check_val({tag, " found3"}, 32'(found3), 32'(ecnt != 0));
      check_val({tag, " x_min3"}, 32'(xmin3), 32'(exmin));
      check_val({tag, " x_max3"}, 32'(xmax3), 32'(exmax));
      check_val({tag, " y_min3"}, 32'(ymin3), 32'(eymin));
      check_val({tag, " y_max3"}, 32'(ymax3), 32'(eymax));
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      threshold = '0;
      clear_frame();
      repeat (3) @(posedge clk_read);
      #1;
      check_val("reset busy1", 32'(busy1), 0);
      check_val("reset done1", 32'(done1), 0);
      check_val("reset addr1", 32'(fb1.read_addr), 0);
      check_val("reset addr3", 32'(fb3.read_addr), 0);
      check_res("reset", 0, 0, 0, 0, 0);
      @(negedge clk_read);
      rst_n = 1'b1;

      // 1: empty frame
      run_scan("t1", 5'd1, 0, 0, 0);
      check_res("t1", 0, 0, 0, 0, 0);

      // 2: single full-white pixel at the maximum threshold
      set_px(10, 20, 9'h1FF);
      run_scan("t2", 5'd21, 0, 0, 0);
      check_res("t2", 1, 10, 10, 20, 20);
      check_val("t2 addr holds last", 32'(fb1.read_addr), 32'(NPIX - 1));

      // 3: red block of brightness 7, at and just above threshold
      clear_frame();
      for (int y = 50; y <= 52; y++)
         for (int x = 40; x <= 43; x++) set_px(x, y, 9'h1C0);
      run_scan("t3a", 5'd7, 0, 0, 0);
      check_res("t3a", 12, 40, 43, 50, 52);
      run_scan("t3b", 5'd8, 0, 0, 0);
      check_res("t3b", 0, 0, 0, 0, 0);

      // 4: first and last pixel of the frame
      clear_frame();
      set_px(0, 0, 9'h1FF);
      set_px(63, 59, 9'h1FF);
      run_scan("t4", 5'd21, 0, 0, 0);
      check_res("t4", 2, 0, 63, 0, 59);

      // 5: start mid-scan and in dut1's DONE cycle are both ignored
      run_scan("t5", 5'd21, 100, NPIX + 1, 0);
      check_res("t5", 2, 0, 63, 0, 59);

      // 6: reset mid-scan, then a fresh scan of a different frame
      run_scan("t6a", 5'd21, 0, 0, 1000);
      rst_n = 1'b0;
      #2;
      check_val("t6 rst busy1", 32'(busy1), 0);
      check_val("t6 rst busy3", 32'(busy3), 0);
      check_val("t6 rst addr1", 32'(fb1.read_addr), 0);
      check_res("t6 rst", 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk_read);
      rst_n = 1'b1;
      repeat (5) @(posedge clk_read);
      #1;
      check_val("t6 idle done1", 32'(done1), 0);
      clear_frame();
      set_px(10, 20, 9'h1FF);
      run_scan("t6b", 5'd21, 0, 0, 0);
      check_res("t6b", 1, 10, 10, 20, 20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
